// File: rtl/player_attack_ctrl.sv
// Per-player attack sequencer: button edges become timed startup/active/recovery/cooldown attacks.
// All state advances only on SCEN game ticks; hitstun aborts any attack.
module player_attack_ctrl #(
  parameter int A1_STARTUP = 3,
  parameter int A1_ACTIVE  = 2,
  parameter int A1_RECOVER = 4,
  parameter int A2_STARTUP = 5,
  parameter int A2_ACTIVE  = 3,
  parameter int A2_RECOVER = 8,
  parameter int COOLDOWN   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCEN,
  input  logic       btn_atk1,
  input  logic       btn_atk2,
  input  logic       hitstun_active,
  input  logic       jump_active,
  output logic       attack_active,
  output logic [1:0] attack_type,
  output logic [5:0] attack_frame,
  output logic       hitbox_active,
  output logic       attack_busy
);
  // state    | meaning
  // IDLE     | no attack, ready to start
  // STARTUP  | wind-up frames, no hitbox
  // ACTIVE   | hitbox live
  // RECOVERY | wind-down, presses are buffered
  // COOLDOWN | lockout after recovery, presses are buffered
  typedef enum logic [2:0] {S_IDLE, S_STARTUP, S_ACTIVE, S_RECOVERY, S_COOLDOWN} state_t;

  localparam logic [6:0] A1_S_END = 7'(A1_STARTUP - 1);
  localparam logic [6:0] A1_A_END = 7'(A1_STARTUP + A1_ACTIVE - 1);
  localparam logic [6:0] A1_R_END = 7'(A1_STARTUP + A1_ACTIVE + A1_RECOVER - 1);
  localparam logic [6:0] A2_S_END = 7'(A2_STARTUP - 1);
  localparam logic [6:0] A2_A_END = 7'(A2_STARTUP + A2_ACTIVE - 1);
  localparam logic [6:0] A2_R_END = 7'(A2_STARTUP + A2_ACTIVE + A2_RECOVER - 1);

  state_t     state;
  logic       prev1, prev2;
  logic       buf_valid;
  logic [1:0] buf_type;
  logic [3:0] cd_cnt;
  logic [1:0] press_type;
  logic       eff_valid;
  logic [1:0] eff_type;
  logic [6:0] end_s, end_a, end_r;
  logic [6:0] frame_ext;

  always_comb begin
    press_type = 2'd0;
    if (btn_atk1 && !prev1)      press_type = 2'd1;
    else if (btn_atk2 && !prev2) press_type = 2'd2;
  end

  // A press on the exit tick itself counts as buffered so it is not lost.
  assign eff_valid = buf_valid || (press_type != 2'd0);
  assign eff_type  = buf_valid ? buf_type : press_type;
  assign frame_ext = {1'b0, attack_frame};

  always_comb begin
    end_s = A1_S_END;
    end_a = A1_A_END;
    end_r = A1_R_END;
    if (attack_type == 2'd2) begin
      end_s = A2_S_END;
      end_a = A2_A_END;
      end_r = A2_R_END;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      prev1         <= 1'b0;
      prev2         <= 1'b0;
      buf_valid     <= 1'b0;
      buf_type      <= 2'd0;
      cd_cnt        <= 4'd0;
      attack_active <= 1'b0;
      attack_type   <= 2'd0;
      attack_frame  <= 6'd0;
      hitbox_active <= 1'b0;
      attack_busy   <= 1'b0;
    end else if (SCEN) begin
      prev1 <= btn_atk1;
      prev2 <= btn_atk2;
      if (hitstun_active) begin
        state         <= S_IDLE;
        buf_valid     <= 1'b0;
        buf_type      <= 2'd0;
        cd_cnt        <= 4'd0;
        attack_active <= 1'b0;
        attack_type   <= 2'd0;
        attack_frame  <= 6'd0;
        hitbox_active <= 1'b0;
        attack_busy   <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (press_type != 2'd0 && !jump_active) begin
              state         <= S_STARTUP;
              attack_type   <= press_type;
              attack_frame  <= 6'd0;
              attack_active <= 1'b1;
              attack_busy   <= 1'b1;
            end
          end
          S_STARTUP: begin
            attack_frame <= attack_frame + 6'd1;
            if (frame_ext == end_s) begin
              state         <= S_ACTIVE;
              hitbox_active <= 1'b1;
            end
          end
          S_ACTIVE: begin
            attack_frame <= attack_frame + 6'd1;
            if (frame_ext == end_a) begin
              state         <= S_RECOVERY;
              hitbox_active <= 1'b0;
            end
          end
          S_RECOVERY, S_COOLDOWN: begin
            if (!buf_valid && press_type != 2'd0) begin
              buf_valid <= 1'b1;
              buf_type  <= press_type;
            end
            if (state == S_RECOVERY) attack_frame <= attack_frame + 6'd1;
            if (state == S_COOLDOWN && cd_cnt != 4'd1) cd_cnt <= cd_cnt - 4'd1;
            if (state == S_RECOVERY && frame_ext == end_r && COOLDOWN != 0) begin
              state         <= S_COOLDOWN;
              cd_cnt        <= 4'(COOLDOWN);
              attack_active <= 1'b0;
              attack_type   <= 2'd0;
              attack_frame  <= 6'd0;
            end else if ((state == S_RECOVERY && frame_ext == end_r) ||
                         (state == S_COOLDOWN && cd_cnt == 4'd1)) begin
              // Exit point: buffered attack chains straight into STARTUP.
              buf_valid <= 1'b0;
              buf_type  <= 2'd0;
              cd_cnt    <= 4'd0;
              if (eff_valid && !jump_active) begin
                state         <= S_STARTUP;
                attack_type   <= eff_type;
                attack_frame  <= 6'd0;
                attack_active <= 1'b1;
                attack_busy   <= 1'b1;
              end else begin
                state         <= S_IDLE;
                attack_active <= 1'b0;
                attack_type   <= 2'd0;
                attack_frame  <= 6'd0;
                attack_busy   <= 1'b0;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_player_attack_ctrl.sv
// Randomized bench for player_attack_ctrl against a frame-count reference model,
// plus directed scenarios with hand-derived expectations.
module tb_player_attack_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       SCEN = 1'b0;
  logic       btn_atk1 = 1'b0, btn_atk2 = 1'b0;
  logic       hitstun_active = 1'b0, jump_active = 1'b0;
  logic       attack_active, hitbox_active, attack_busy;
  logic [1:0] attack_type;
  logic [5:0] attack_frame;

  int checks = 0;
  int errors = 0;

  localparam int S1 = 3, AC1 = 2, R1 = 4, S2 = 5, AC2 = 3, R2 = 8, CD = 2;

  player_attack_ctrl dut (
    .clk(clk), .reset(reset), .SCEN(SCEN), .btn_atk1(btn_atk1), .btn_atk2(btn_atk2),
    .hitstun_active(hitstun_active), .jump_active(jump_active),
    .attack_active(attack_active), .attack_type(attack_type), .attack_frame(attack_frame),
    .hitbox_active(hitbox_active), .attack_busy(attack_busy)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 attacking (frame counts up), 2 cooling down
  int m_mode, m_type, m_frame, m_cd, m_bt;
  bit m_bv, m_p1, m_p2;

  task automatic model_reset();
    m_mode = 0; m_type = 0; m_frame = 0; m_cd = 0; m_bv = 0; m_bt = 0; m_p1 = 0; m_p2 = 0;
  endtask

  function automatic int len_s(int t); return (t == 2) ? S2 : S1; endfunction
  function automatic int len_a(int t); return (t == 2) ? AC2 : AC1; endfunction
  function automatic int len_r(int t); return (t == 2) ? R2 : R1; endfunction

  task automatic model_finish(input bit jp);
    bit v; int t;
    v = m_bv; t = m_bt; m_bv = 0; m_bt = 0;
    if (v && !jp) begin m_mode = 1; m_type = t; m_frame = 0; end
    else m_mode = 0;
  endtask

  task automatic model_tick(input bit b1, input bit b2, input bit hs, input bit jp);
    int pt;
    pt = (b1 && !m_p1) ? 1 : (b2 && !m_p2) ? 2 : 0;
    m_p1 = b1; m_p2 = b2;
    if (hs) begin
      m_mode = 0; m_bv = 0; m_bt = 0;
    end else if (m_mode == 0) begin
      if (pt != 0 && !jp) begin m_mode = 1; m_type = pt; m_frame = 0; end
    end else if (m_mode == 1) begin
      if (m_frame >= len_s(m_type) + len_a(m_type) && pt != 0 && !m_bv) begin m_bv = 1; m_bt = pt; end
      if (m_frame == len_s(m_type) + len_a(m_type) + len_r(m_type) - 1) begin
        if (CD > 0) begin m_mode = 2; m_cd = CD; end
        else model_finish(jp);
      end else m_frame++;
    end else begin
      if (pt != 0 && !m_bv) begin m_bv = 1; m_bt = pt; end
      m_cd--;
      if (m_cd == 0) model_finish(jp);
    end
  endtask

  function automatic logic [10:0] model_vec();
    bit att, hb;
    att = (m_mode == 1);
    hb  = att && m_frame >= len_s(m_type) && m_frame < len_s(m_type) + len_a(m_type);
    return {att, att ? 2'(m_type) : 2'd0, att ? 6'(m_frame) : 6'd0, hb, m_mode != 0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model on SCEN ticks, compare after the edge.
  task automatic tick(input bit scen, input bit b1, input bit b2, input bit hs, input bit jp);
    SCEN = scen; btn_atk1 = b1; btn_atk2 = b2; hitstun_active = hs; jump_active = jp;
    @(posedge clk); #1;
    if (scen) model_tick(b1, b2, hs, jp);
    check("model", {21'd0, attack_active, attack_type, attack_frame, hitbox_active, attack_busy},
          {21'd0, model_vec()});
  endtask

  initial begin
    bit b1, b2, hs, jp, sc;
    int rises, hb_cnt, max_frame;
    logic last_act;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_outs", {attack_active, attack_type, attack_frame, hitbox_active, attack_busy}, 0);

    // Plan 1: ATK1 timeline
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    check("a1_start", {attack_active, attack_type, attack_frame}, {1'b1, 2'd1, 6'd0});
    check("a1_hb0", hitbox_active, 0);
    for (int i = 1; i <= 8; i++) begin
      tick(1, 1, 0, 0, 0);
      check("a1_frame", attack_frame, i);
      check("a1_hb", hitbox_active, (i == 3 || i == 4));
    end
    tick(1, 0, 0, 0, 0);
    check("a1_cd1", {attack_active, attack_busy}, 2'b01);
    tick(1, 0, 0, 0, 0);
    check("a1_cd2", attack_busy, 1);
    tick(1, 0, 0, 0, 0);
    check("a1_idle", attack_busy, 0);

    // Plan 2: held ATK2 fires once
    rises = 0; hb_cnt = 0; max_frame = 0; last_act = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1, 0, 1, 0, 0);
      if (attack_active && !last_act) rises++;
      if (hitbox_active) hb_cnt++;
      if (attack_active && attack_frame > max_frame) max_frame = attack_frame;
      last_act = attack_active;
    end
    check("a2_once", rises, 1);
    check("a2_hb_len", hb_cnt, 3);
    check("a2_last", max_frame, 15);
    tick(1, 0, 0, 0, 0);

    // Plan 3: hitstun abort then restart
    tick(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0);
    check("abort", {attack_active, attack_type, attack_frame, hitbox_active, attack_busy}, 0);
    tick(1, 1, 0, 0, 0);
    check("restart", {attack_type, attack_frame}, {2'd1, 6'd0});
    for (int i = 0; i < 12; i++) tick(1, 0, 0, 0, 0);

    // Plan 4: buffered ATK2 chains after cooldown
    tick(1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick(1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 0);
      check("chain_busy", attack_busy, 1);
    end
    check("chain_a2", {attack_active, attack_type, attack_frame}, {1'b1, 2'd2, 6'd0});
    for (int i = 0; i < 20; i++) tick(1, 0, 0, 0, 0);

    // Plan 5: press while jumping is dropped
    tick(1, 1, 0, 0, 1);
    check("jump_block", attack_busy, 0);
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    check("jump_nobuf", attack_busy, 0);
    tick(1, 0, 0, 0, 0);

    // Plan 6: async reset mid-ACTIVE, then SCEN=0 freeze
    tick(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0);
    check("pre_rst_hb", hitbox_active, 1);
    #3 reset = 1'b1;
    #1 check("async_rst", {attack_active, attack_type, attack_frame, hitbox_active, attack_busy}, 0);
    model_reset();
    #2 reset = 1'b0;
    tick(1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, i[0], ~i[0], 0, 0);
    check("freeze", {attack_type, attack_frame}, {2'd1, 6'd0});
    for (int i = 0; i < 20; i++) tick(1, 0, 0, 0, 0);

    // Randomized run against the model
    b1 = 0; b2 = 0;
    for (int i = 0; i < 4000; i++) begin
      sc = ($urandom_range(99) < 75);
      if ($urandom_range(99) < 20) b1 = ~b1;
      if ($urandom_range(99) < 15) b2 = ~b2;
      hs = ($urandom_range(99) < 3);
      jp = ($urandom_range(99) < 10);
      tick(sc, b1, b2, hs, jp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/player_attack_ctrl.md
Name: player_attack_ctrl

Overview:
Per-player attack sequencer. Turns attack button presses into a timed attack: startup, then active (hitbox live), then recovery, then cooldown. It produces attack_active, attack_type and attack_frame for the player animation state stage, and hitbox_active for the hit resolver. Hitstun from the resolver aborts an attack. All timing advances only on SCEN game ticks.

Parameters:
A1_STARTUP, 3, ATK1 startup length in ticks (>=1)
A1_ACTIVE, 2, ATK1 active/hitbox length in ticks (>=1)
A1_RECOVER, 4, ATK1 recovery length in ticks (>=1)
A2_STARTUP, 5, ATK2 startup length in ticks (>=1)
A2_ACTIVE, 3, ATK2 active length in ticks (>=1)
A2_RECOVER, 8, ATK2 recovery length in ticks (>=1)
COOLDOWN, 2, idle lockout after recovery in ticks (0..15)
Constraint: STARTUP+ACTIVE+RECOVER <= 64 for each attack type.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
SCEN  in  1  game-tick enable; state changes only on clk edges where SCEN=1
btn_atk1  in  1  raw light-attack button level
btn_atk2  in  1  raw heavy-attack button level
hitstun_active  in  1  from resolver; aborts or blocks attacks
jump_active  in  1  from move module; blocks attack start
attack_active  out  1  high in STARTUP/ACTIVE/RECOVERY
attack_type  out  2  1=ATK1, 2=ATK2, 0 when not attacking
attack_frame  out  6  ticks elapsed since attack start, 0-based
hitbox_active  out  1  high only in ACTIVE phase
attack_busy  out  1  high in any state except IDLE (includes COOLDOWN)

Behaviour:
- Reset is asynchronous and active-high. Reset values: state=IDLE, all outputs 0, edge registers 0, buffer empty.
- Edge detect: button levels are sampled into prev registers on SCEN ticks only. A press is btn=1 with prev=0 on that tick. Holding a button does not retrigger.
- Both press edges on the same tick: ATK1 wins and ATK2 is discarded.
- States: IDLE, STARTUP, ACTIVE, RECOVERY, COOLDOWN. Outputs are registered and decoded from state, so they reflect state after the edge.
- IDLE -> STARTUP: on a SCEN tick with a press (or a buffered press), hitstun_active=0 and jump_active=0. On that edge attack_type is set, attack_frame=0 and attack_active=1. A press while jumping or in hitstun is dropped, not buffered.
- Phase counter: each SCEN tick in an attack state increments attack_frame. The phase change occurs when attack_frame reaches the phase boundary:
  - STARTUP covers frames 0..S-1.
  - ACTIVE covers frames S..S+A-1.
  - RECOVERY covers frames S+A..S+A+R-1.
  - S/A/R are selected by the latched attack_type.
- Leaving recovery: after the last RECOVERY frame, go to COOLDOWN with attack_active=0, attack_type=0, attack_frame=0. If COOLDOWN=0, go to IDLE instead.
- COOLDOWN counts COOLDOWN ticks, then returns to IDLE.
- Input buffer: one entry (valid + type).
  - A press edge during RECOVERY or COOLDOWN is stored. The first press wins; later presses are ignored while the buffer is valid.
  - Presses during STARTUP/ACTIVE are ignored.
  - A buffered press starts the next attack on the same edge the block would otherwise enter IDLE. It goes straight to STARTUP with frame 0, provided hitstun_active=0 and jump_active=0 on that tick. The buffer clears when consumed.
  - If the start is blocked, the buffer is cleared and the block enters IDLE.
- Hitstun abort: hitstun_active=1 on any SCEN tick, in any state, forces IDLE. All outputs go to 0 and the buffer is cleared on that edge. Abort has priority over every other transition.
- SCEN=0: all registers hold, including edge-detect prev registers.
- attack_frame never exceeds 63, which the parameter constraint guarantees.

Test Plan:
1. Defaults; btn_atk1 rises, SCEN every cycle -> next edge attack_active=1, type=1, frame=0. hitbox_active=1 at frames 3-4 only. attack_active drops after frame 8 (9 active ticks). attack_busy stays high 2 more ticks, then IDLE.
2. btn_atk2 held high for 30 ticks -> exactly one ATK2. hitbox_active at frames 5-7, last frame 15, no retrigger while held.
3. ATK1 running; at frame 4 assert hitstun_active for one tick -> next edge all outputs 0, IDLE. A btn_atk1 edge 1 tick later starts a new ATK1 at frame 0.
4. During ATK1 frame 6 press atk2, then at frame 7 press atk1 -> after 2 cooldown ticks ATK2 starts directly with frame 0, with no IDLE tick in between. The atk1 press is lost.
5. jump_active=1 with a btn_atk1 edge -> no attack, buffer empty. Later release jump with no new press -> still IDLE.
6. Assert reset asynchronously mid-ACTIVE (between clock edges) -> outputs 0 immediately. With SCEN=0 and a button toggling, outputs stay frozen.
